// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and job payload for the fixed-to-float conversion scheduler.
package conv_pkg;

    localparam int unsigned FIX_W = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned FLT_W = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    typedef struct packed {
        logic [FIX_W-1:0] fixed;
        logic [EXP_W-1:0] exp;
    } conv_job_t;

endpackage

// File: rtl/conv_scheduler_if.sv
// Request, converter and response buses of the conversion scheduler.
interface conv_scheduler_if
    import conv_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*FIX_W-1:0] req_fixed;
    logic [N_REQ*EXP_W-1:0] req_exp;
    logic [FIX_W-1:0]       conv_fixed;
    logic [EXP_W-1:0]       conv_exp;
    logic                   conv_load;
    logic [FLT_W-1:0]       conv_float;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [FLT_W-1:0]       resp_float;

    // Scheduler side
    modport master (
        input  req_valid, req_fixed, req_exp, conv_float, resp_ready,
        output req_ready, conv_fixed, conv_exp, conv_load, resp_valid, resp_id, resp_float
    );

    // Requesters, converter and result consumer side
    modport slave (
        output req_valid, req_fixed, req_exp, conv_float, resp_ready,
        input  req_ready, conv_fixed, conv_exp, conv_load, resp_valid, resp_id, resp_float
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester after ptr wins, with wrap-around.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Round-robin scheduler sharing one fixed-to-float converter between N_REQ requesters.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CONV_LATENCY = 40,
    localparam int unsigned ID_W  = $clog2(N_REQ),
    localparam int unsigned CNT_W = $clog2(CONV_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    conv_scheduler_if.master bus,
    output logic             busy
);
    logic [1:0]       state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    conv_job_t        job, job_nxt;
    logic             conv_load, conv_load_nxt;
    logic             resp_valid, resp_valid_nxt;
    logic [ID_W-1:0]  resp_id, resp_id_nxt;
    logic [FLT_W-1:0] resp_float, resp_float_nxt;
    logic             busy_nxt;
    logic [N_REQ-1:0] grant, req_ready_c;
    logic [ID_W-1:0]  gidx;
    logic [FIX_W-1:0] fixed_arr [N_REQ];
    logic [EXP_W-1:0] exp_arr   [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign fixed_arr[i] = bus.req_fixed[i*FIX_W +: FIX_W];
        assign exp_arr[i]   = bus.req_exp[i*EXP_W +: EXP_W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // Next-state and next-output logic; req_ready is the only combinational output
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        cnt_nxt        = cnt;
        job_nxt        = job;
        conv_load_nxt  = 1'b0;
        resp_valid_nxt = resp_valid;
        resp_id_nxt    = resp_id;
        resp_float_nxt = resp_float;
        req_ready_c    = '0;
        unique case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c   = grant;
                    job_nxt       = '{fixed: fixed_arr[gidx], exp: exp_arr[gidx]};
                    ptr_nxt       = gidx;
                    conv_load_nxt = 1'b1;
                    state_nxt     = LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = CNT_W'(CONV_LATENCY);
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    resp_float_nxt = bus.conv_float;
                    resp_id_nxt    = ptr;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Reset drops any job in flight and restarts rotation at requester 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= ID_W'(N_REQ - 1);
            cnt        <= '0;
            job        <= '0;
            conv_load  <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_float <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            job        <= job_nxt;
            conv_load  <= conv_load_nxt;
            resp_valid <= resp_valid_nxt;
            resp_id    <= resp_id_nxt;
            resp_float <= resp_float_nxt;
            busy       <= busy_nxt;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.conv_fixed = job.fixed;
    assign bus.conv_exp   = job.exp;
    assign bus.conv_load  = conv_load;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_id    = resp_id;
    assign bus.resp_float = resp_float;

endmodule
